ts_packet_arbiter: RTL

- Round-robin scheduler that shares one downstream byte path between the per-channel reclock FIFOs of the 4-channel tuner front end.
- Monitors each channel's full-packet flag and grants one channel at a time.
- Issues that channel's FIFO read requests for exactly one 188-byte TS packet.
- Emits the bytes as a tagged stream (start, end, channel number) in the SYS_CLK domain, with sync-byte checking.

---
 rtl/ts_packet_arbiter.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/ts_packet_arbiter.sv
// Round-robin arbiter: grants one eligible channel at a time and drains exactly one
// TS packet from its reclock FIFO into a tagged byte stream (SOP/EOP/channel/sync check).
//
// state | meaning
// IDLE  | no grant; pick next eligible channel after last_ch
// READ  | issuing FIFO reads for the granted channel until PKT_LEN bytes or disable
module ts_packet_arbiter #(
    parameter int          N_CH      = 4,
    parameter int          CH_W      = 2,
    parameter int          PKT_LEN   = 188,
    parameter logic [7:0]  SYNC_BYTE = 8'h47
) (
    input  logic              SYS_CLK,
    input  logic              RST,
    input  logic [N_CH-1:0]   PKT_READY,
    input  logic [N_CH-1:0]   CH_ENABLE,
    input  logic [8*N_CH-1:0] DATA_IN,
    input  logic              OUT_READY,
    output logic [N_CH-1:0]   RD_REQ,
    output logic [7:0]        OUT_DATA,
    output logic              OUT_VALID,
    output logic              OUT_SOP,
    output logic              OUT_EOP,
    output logic [CH_W-1:0]   OUT_CH,
    output logic              SYNC_ERR,
    output logic              ABORT,
    output logic              BUSY
);

    localparam int CNT_W = $clog2(PKT_LEN);

    typedef enum logic {ST_IDLE, ST_READ} state_t;

    state_t            state_q;
    logic [CH_W-1:0]   grant_q;
    logic [CH_W-1:0]   last_ch_q;
    logic [CNT_W-1:0]  byte_cnt_q;
    logic              abort_q;

    logic              s1_valid_q;
    logic              s1_sop_q;
    logic              s1_eop_q;
    logic [CH_W-1:0]   s1_ch_q;

    logic [7:0]        out_data_q;
    logic              out_valid_q;
    logic              out_sop_q;
    logic              out_eop_q;
    logic [CH_W-1:0]   out_ch_q;
    logic              sync_err_q;

    logic [N_CH-1:0]   elig;
    logic              any_elig;
    logic [CH_W-1:0]   pick_ch;
    logic [CH_W-1:0]   cand;
    logic              rd_en;
    logic              last_byte;
    logic [7:0]        byte_sel_d;

    assign elig      = PKT_READY & CH_ENABLE;
    assign rd_en     = (state_q == ST_READ) & OUT_READY & CH_ENABLE[grant_q];
    assign last_byte = (byte_cnt_q == CNT_W'(PKT_LEN - 1));

    // Search upward from the channel after last_ch, wrapping, first hit wins.
    always_comb begin
        any_elig = 1'b0;
        pick_ch  = '0;
        cand     = '0;
        for (int i = 1; i <= N_CH; i++) begin
            cand = CH_W'((int'(last_ch_q) + i) % N_CH);
            if (!any_elig && elig[cand]) begin
                any_elig = 1'b1;
                pick_ch  = cand;
            end
        end
    end

    always_comb begin
        RD_REQ = '0;
        if (rd_en) begin
            RD_REQ[grant_q] = 1'b1;
        end
    end

    always_ff @(posedge SYS_CLK or negedge RST) begin
        if (!RST) begin
            state_q    <= ST_IDLE;
            grant_q    <= '0;
            last_ch_q  <= CH_W'(N_CH - 1);
            byte_cnt_q <= '0;
            abort_q    <= 1'b0;
        end else begin
            abort_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (any_elig) begin
                        grant_q    <= pick_ch;
                        last_ch_q  <= pick_ch;
                        byte_cnt_q <= '0;
                        state_q    <= ST_READ;
                    end
                end
                ST_READ: begin
                    if (!CH_ENABLE[grant_q]) begin
                        state_q <= ST_IDLE;
                        abort_q <= 1'b1;
                    end else if (rd_en) begin
                        byte_cnt_q <= byte_cnt_q + 1'b1;
                        if (last_byte) begin
                            state_q <= ST_IDLE;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // FIFO data lags its read strobe by one cycle, so select it with the stage-1 channel tag.
    assign byte_sel_d = DATA_IN[{s1_ch_q, 3'b000} +: 8];

    always_ff @(posedge SYS_CLK or negedge RST) begin
        if (!RST) begin
            s1_valid_q  <= 1'b0;
            s1_sop_q    <= 1'b0;
            s1_eop_q    <= 1'b0;
            s1_ch_q     <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_sop_q   <= 1'b0;
            out_eop_q   <= 1'b0;
            out_ch_q    <= '0;
            sync_err_q  <= 1'b0;
        end else begin
            s1_valid_q  <= rd_en;
            s1_sop_q    <= (byte_cnt_q == '0);
            s1_eop_q    <= last_byte;
            s1_ch_q     <= grant_q;
            out_valid_q <= s1_valid_q;
            out_sop_q   <= s1_valid_q & s1_sop_q;
            out_eop_q   <= s1_valid_q & s1_eop_q;
            sync_err_q  <= s1_valid_q & s1_sop_q & (byte_sel_d != SYNC_BYTE);
            if (s1_valid_q) begin
                out_data_q <= byte_sel_d;
                out_ch_q   <= s1_ch_q;
            end
        end
    end

    assign OUT_DATA  = out_data_q;
    assign OUT_VALID = out_valid_q;
    assign OUT_SOP   = out_sop_q;
    assign OUT_EOP   = out_eop_q;
    assign OUT_CH    = out_ch_q;
    assign SYNC_ERR  = sync_err_q;
    assign ABORT     = abort_q;
    assign BUSY      = (state_q == ST_READ);

endmodule
